// File: rtl/nes_bus_pkg.sv
// Shared types and constants for the NES CPU-side bus controller.
// Holds the region encoding, region base addresses and the FSM state type.
package nes_bus_pkg;

  typedef enum logic [2:0] {
    REG_RAM      = 3'd0,
    REG_IO       = 3'd1,
    REG_UNMAPPED = 3'd2,
    REG_SRAM     = 3'd3,
    REG_ROM      = 3'd4
  } region_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } bus_state_e;

  localparam logic [15:0] RAM_BASE      = 16'h0000;
  localparam logic [15:0] IO_BASE       = 16'h2000;
  localparam logic [15:0] UNMAPPED_BASE = 16'h4000;
  localparam logic [15:0] SRAM_BASE     = 16'h6000;
  localparam logic [15:0] ROM_BASE      = 16'h8000;

  // Region is selected purely by the top three address bits.
  function automatic region_e decode_region(input logic [2:0] top_bits);
    region_e r;
    case (top_bits)
      3'b000:  r = REG_RAM;
      3'b001:  r = REG_IO;
      3'b010:  r = REG_UNMAPPED;
      3'b011:  r = REG_SRAM;
      default: r = REG_ROM;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/nes_bus_decode.sv
// Combinational address decoder: maps a 6502 address to region, raw index
// and the wait-state count configured for that region.
module nes_bus_decode
  import nes_bus_pkg::*;
#(
  parameter logic [3:0] WAIT_RAM  = 4'd0,
  parameter logic [3:0] WAIT_IO   = 4'd0,
  parameter logic [3:0] WAIT_SRAM = 4'd1,
  parameter logic [3:0] WAIT_ROM  = 4'd1
) (
  input  logic [15:0] addr,
  output region_e     region,
  output logic [14:0] index,
  output logic [3:0]  wait_cycles
);

  always_comb begin
    region      = decode_region(addr[15:13]);
    index       = addr[14:0];
    wait_cycles = WAIT_RAM;
    // Unmapped space shares the RAM timing.
    case (region)
      REG_IO:   wait_cycles = WAIT_IO;
      REG_SRAM: wait_cycles = WAIT_SRAM;
      REG_ROM:  wait_cycles = WAIT_ROM;
      default:  wait_cycles = WAIT_RAM;
    endcase
  end

endmodule

// File: rtl/nes_cpu_bus_ctrl.sv
// CPU-side bus controller: region decode, per-region wait states, backing
// storage and ROM loader port. Optional error reporting under BUS_CTRL_ERR_EN.
module nes_cpu_bus_ctrl
  import nes_bus_pkg::*;
#(
  parameter int         DATA_W    = 8,
  parameter int         RAM_AW    = 11,
  parameter int         IO_AW     = 3,
  parameter int         SRAM_AW   = 13,
  parameter int         ROM_AW    = 15,
  parameter logic [3:0] WAIT_RAM  = 4'd0,
  parameter logic [3:0] WAIT_IO   = 4'd0,
  parameter logic [3:0] WAIT_SRAM = 4'd1,
  parameter logic [3:0] WAIT_ROM  = 4'd1
) (
  input  logic              clk,
  input  logic              b_rst,
  input  logic [15:0]       cpu_addr_out,
  input  logic [DATA_W-1:0] cpu_data_out,
  input  logic              ren,
  input  logic              wen,
  output logic [DATA_W-1:0] cpu_data_in,
  output logic              rdy,
  input  logic              ld_valid,
  input  logic [ROM_AW-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              bus_err,
  output logic [7:0]        err_cnt
);

  region_e     dec_region;
  logic [14:0] dec_index;
  logic [3:0]  dec_wait;

  nes_bus_decode #(
    .WAIT_RAM  (WAIT_RAM),
    .WAIT_IO   (WAIT_IO),
    .WAIT_SRAM (WAIT_SRAM),
    .WAIT_ROM  (WAIT_ROM)
  ) u_decode (
    .addr        (cpu_addr_out),
    .region      (dec_region),
    .index       (dec_index),
    .wait_cycles (dec_wait)
  );

  bus_state_e        state_q, state_d;
  logic [3:0]        wait_cnt_q, wait_cnt_d;
  region_e           region_q, region_d;
  logic [14:0]       index_q, index_d;
  logic              is_read_q, is_read_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [DATA_W-1:0] cpu_data_in_q, cpu_data_in_d;

  logic [DATA_W-1:0] ram_mem  [2**RAM_AW];
  logic [DATA_W-1:0] io_mem   [2**IO_AW];
  logic [DATA_W-1:0] sram_mem [2**SRAM_AW];
  logic [DATA_W-1:0] rom_mem  [2**ROM_AW];

  logic              accept, complete, wr_fire, ld_fire;
  region_e           acc_region;
  logic [14:0]       acc_index;
  logic              acc_read;
  logic [DATA_W-1:0] acc_wdata, rd_data;
  logic              unused_index;

  // In IDLE the live CPU request is used; in WAIT the values latched at accept.
  always_comb begin
    accept     = (state_q == IDLE) && (ren || wen);
    acc_region = (state_q == IDLE) ? dec_region : region_q;
    acc_index  = (state_q == IDLE) ? dec_index : index_q;
    acc_read   = (state_q == IDLE) ? ren : is_read_q;
    acc_wdata  = (state_q == IDLE) ? cpu_data_out : wdata_q;
    complete   = accept ? (dec_wait == 4'd0)
                        : ((state_q == WAIT) && (wait_cnt_q == 4'd1));

    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    region_d   = region_q;
    index_d    = index_q;
    is_read_d  = is_read_q;
    wdata_d    = wdata_q;
    if (accept) begin
      region_d  = dec_region;
      index_d   = dec_index;
      is_read_d = ren;
      wdata_d   = cpu_data_out;
      if (dec_wait != 4'd0) begin
        state_d    = WAIT;
        wait_cnt_d = dec_wait;
      end
    end else if (state_q == WAIT) begin
      if (wait_cnt_q == 4'd1) begin
        state_d    = IDLE;
        wait_cnt_d = 4'd0;
      end else begin
        wait_cnt_d = wait_cnt_q - 4'd1;
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (acc_region)
      REG_RAM:  rd_data = ram_mem[acc_index[RAM_AW-1:0]];
      REG_IO:   rd_data = io_mem[acc_index[IO_AW-1:0]];
      REG_SRAM: rd_data = sram_mem[acc_index[SRAM_AW-1:0]];
      REG_ROM:  rd_data = rom_mem[acc_index[ROM_AW-1:0]];
      default:  rd_data = '0;
    endcase
    // Unmapped reads leave the previous value on the bus.
    cpu_data_in_d = cpu_data_in_q;
    if (complete && acc_read && (acc_region != REG_UNMAPPED))
      cpu_data_in_d = rd_data;
  end

  assign wr_fire      = complete && !acc_read && b_rst;
  assign ld_ready     = b_rst && (state_q == IDLE) && !ren && !wen;
  assign ld_fire      = ld_valid && ld_ready;
  assign unused_index = ^acc_index;

  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      state_q       <= IDLE;
      wait_cnt_q    <= 4'd0;
      region_q      <= REG_RAM;
      index_q       <= '0;
      is_read_q     <= 1'b0;
      wdata_q       <= '0;
      cpu_data_in_q <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      region_q      <= region_d;
      index_q       <= index_d;
      is_read_q     <= is_read_d;
      wdata_q       <= wdata_d;
      cpu_data_in_q <= cpu_data_in_d;
    end
  end

  // Storage is never reset; CPU writes to ROM are dropped, only the loader fills it.
  always_ff @(posedge clk) begin
    if (wr_fire && (acc_region == REG_RAM))
      ram_mem[acc_index[RAM_AW-1:0]] <= acc_wdata;
    if (wr_fire && (acc_region == REG_IO))
      io_mem[acc_index[IO_AW-1:0]] <= acc_wdata;
    if (wr_fire && (acc_region == REG_SRAM))
      sram_mem[acc_index[SRAM_AW-1:0]] <= acc_wdata;
    if (ld_fire)
      rom_mem[ld_addr] <= ld_data;
  end

  assign rdy         = (state_q == IDLE);
  assign cpu_data_in = cpu_data_in_q;

`ifdef BUS_CTRL_ERR_EN
  logic       err_event;
  logic       bus_err_q, bus_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  always_comb begin
    err_event = accept && ((dec_region == REG_UNMAPPED) || (ren && wen) ||
                           (!ren && wen && (dec_region == REG_ROM)));
    bus_err_d = err_event;
    err_cnt_d = err_cnt_q;
    if (err_event && (err_cnt_q != 8'hFF))
      err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge b_rst) begin
    if (!b_rst) begin
      bus_err_q <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      bus_err_q <= bus_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign bus_err = bus_err_q;
  assign err_cnt = err_cnt_q;
`else
  assign bus_err = 1'b0;
  assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_nes_cpu_bus_ctrl.sv
// Self-checking bench for nes_cpu_bus_ctrl with WAIT_ROM=3; error checks
// adapt to whether BUS_CTRL_ERR_EN is defined.
module tb_nes_cpu_bus_ctrl;

`ifdef BUS_CTRL_ERR_EN
  localparam logic ERR_ON = 1'b1;
`else
  localparam logic ERR_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        b_rst = 1'b0;
  logic [15:0] cpu_addr_out = 16'h0000;
  logic [7:0]  cpu_data_out = 8'h00;
  logic        ren = 1'b0;
  logic        wen = 1'b0;
  logic [7:0]  cpu_data_in;
  logic        rdy;
  logic        ld_valid = 1'b0;
  logic [14:0] ld_addr = 15'h0000;
  logic [7:0]  ld_data = 8'h00;
  logic        ld_ready;
  logic        bus_err;
  logic [7:0]  err_cnt;

  int checks = 0;
  int passes = 0;

  typedef struct {
    logic        r;
    logic        w;
    logic [15:0] addr;
    logic [7:0]  wd;
    logic [7:0]  exp_data;
    logic        exp_err;
    string       name;
  } vec_t;

  vec_t vecs[11];

  always #5 clk = ~clk;

  nes_cpu_bus_ctrl #(
    .WAIT_ROM (4'd3)
  ) dut (
    .clk          (clk),
    .b_rst        (b_rst),
    .cpu_addr_out (cpu_addr_out),
    .cpu_data_out (cpu_data_out),
    .ren          (ren),
    .wen          (wen),
    .cpu_data_in  (cpu_data_in),
    .rdy          (rdy),
    .ld_valid     (ld_valid),
    .ld_addr      (ld_addr),
    .ld_data      (ld_data),
    .ld_ready     (ld_ready),
    .bus_err      (bus_err),
    .err_cnt      (err_cnt)
  );

  task automatic check_output(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %b, expected %b", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU access: accept this cycle, expect rdy low for 'waits' cycles
  // (inputs scrambled meanwhile), then rdy high with the expected read data.
  task automatic apply_stimulus(input logic r, input logic w, input logic [15:0] addr,
                                input logic [7:0] wd, input int waits,
                                input logic [7:0] exp_data, input logic exp_err,
                                input string name);
    ren = r;
    wen = w;
    cpu_addr_out = addr;
    cpu_data_out = wd;
    tick();
    check_bit({name, "_err"}, bus_err, exp_err & ERR_ON);
    for (int i = 0; i < waits; i++) begin
      check_bit({name, "_rdy_low"}, rdy, 1'b0);
      ren = 1'b0;
      wen = 1'b0;
      cpu_addr_out = addr ^ 16'h5555;
      cpu_data_out = ~wd;
      #1;
      check_bit({name, "_ldrdy_wait"}, ld_ready, 1'b0);
      tick();
    end
    check_bit({name, "_rdy"}, rdy, 1'b1);
    check_output({name, "_data"}, cpu_data_in, exp_data);
    ren = 1'b0;
    wen = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 16'h0005, 8'h5A, 8'h00, 1'b0, "ram_wr_5A"};
    vecs[1]  = '{1'b1, 1'b0, 16'h0805, 8'h00, 8'h5A, 1'b0, "ram_mirror_rd"};
    vecs[2]  = '{1'b0, 1'b1, 16'h2003, 8'h11, 8'h5A, 1'b0, "io_wr"};
    vecs[3]  = '{1'b1, 1'b0, 16'h3FFB, 8'h00, 8'h11, 1'b0, "io_mirror_rd"};
    vecs[4]  = '{1'b0, 1'b1, 16'h1FFF, 8'h33, 8'h11, 1'b0, "ram_wr_top"};
    vecs[5]  = '{1'b1, 1'b0, 16'h07FF, 8'h00, 8'h33, 1'b0, "ram_rd_top"};
    vecs[6]  = '{1'b1, 1'b0, 16'h4000, 8'h00, 8'h33, 1'b1, "open_bus_rd"};
    vecs[7]  = '{1'b0, 1'b1, 16'h4001, 8'h99, 8'h33, 1'b1, "unmapped_wr"};
    vecs[8]  = '{1'b1, 1'b0, 16'h0005, 8'h00, 8'h5A, 1'b0, "ram_rd_5A"};
    vecs[9]  = '{1'b1, 1'b1, 16'h0805, 8'h77, 8'h5A, 1'b1, "ren_wen_rd"};
    vecs[10] = '{1'b1, 1'b0, 16'h0005, 8'h00, 8'h5A, 1'b0, "ram_not_written"};

    // Reset values
    #12;
    check_bit("rst_rdy", rdy, 1'b1);
    check_output("rst_data", cpu_data_in, 8'h00);
    check_bit("rst_ld_ready", ld_ready, 1'b0);
    check_bit("rst_bus_err", bus_err, 1'b0);
    check_output("rst_err_cnt", err_cnt, 8'h00);
    tick();
    b_rst = 1'b1;
    #1;
    check_bit("idle_ld_ready", ld_ready, 1'b1);

    // Fill ROM through the loader
    ld_valid = 1'b1;
    ld_addr  = 15'h7FFC;
    ld_data  = 8'h00;
    tick();
    ld_addr  = 15'h0000;
    ld_data  = 8'hC3;
    tick();
    ld_valid = 1'b0;

    // ROM write ignored, then reads with three wait states
    apply_stimulus(1'b0, 1'b1, 16'h8000, 8'hAA, 3, 8'h00, 1'b1, "rom_wr");
    apply_stimulus(1'b1, 1'b0, 16'h8000, 8'h00, 3, 8'hC3, 1'b0, "rom_rd_8000");
    check_output("err_cnt_rom_wr", err_cnt, ERR_ON ? 8'd1 : 8'd0);
    apply_stimulus(1'b1, 1'b0, 16'hFFFC, 8'h00, 3, 8'h00, 1'b0, "rom_rd_fffc");

    // Zero-wait vectors, issued back to back
    for (int i = 0; i < 11; i++)
      apply_stimulus(vecs[i].r, vecs[i].w, vecs[i].addr, vecs[i].wd, 0,
                     vecs[i].exp_data, vecs[i].exp_err, vecs[i].name);
    check_output("err_cnt_table", err_cnt, ERR_ON ? 8'd4 : 8'd0);

    // SRAM write, read back, then reset in the middle of a second write
    apply_stimulus(1'b0, 1'b1, 16'h6010, 8'h42, 1, 8'h5A, 1'b0, "sram_wr");
    apply_stimulus(1'b1, 1'b0, 16'h6010, 8'h00, 1, 8'h42, 1'b0, "sram_rd");
    wen = 1'b1;
    cpu_addr_out = 16'h6010;
    cpu_data_out = 8'h99;
    tick();
    check_bit("sram_wr2_rdy_low", rdy, 1'b0);
    b_rst = 1'b0;
    wen = 1'b0;
    #1;
    check_bit("mid_rst_rdy", rdy, 1'b1);
    check_output("mid_rst_data", cpu_data_in, 8'h00);
    check_output("mid_rst_err_cnt", err_cnt, 8'h00);
    tick();
    b_rst = 1'b1;
    apply_stimulus(1'b1, 1'b0, 16'h6010, 8'h00, 1, 8'h42, 1'b0, "sram_after_rst");

    // Loader held while CPU is busy: only accepted once the CPU goes idle
    ld_valid = 1'b1;
    ld_addr  = 15'h0100;
    ld_data  = 8'h6E;
    ren = 1'b1;
    cpu_addr_out = 16'h0005;
    #1;
    check_bit("ld_blocked_0", ld_ready, 1'b0);
    tick();
    check_output("cpu_rd_during_ld", cpu_data_in, 8'h5A);
    check_bit("ld_blocked_1", ld_ready, 1'b0);
    tick();
    ren = 1'b0;
    #1;
    check_bit("ld_accepted", ld_ready, 1'b1);
    tick();
    ld_valid = 1'b0;
    apply_stimulus(1'b1, 1'b0, 16'h8100, 8'h00, 3, 8'h6E, 1'b0, "rom_rd_loaded");

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
